// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEPTH_DEFAULT   = 256;
  localparam int LATENCY_DEFAULT = 2;
  localparam int CNT_W           = 3;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write with enable, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     i_wen,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_wen) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, stalls the pipeline for
// LATENCY cycles, then pulses resp_valid with registered results.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_wen,
  input  logic        req_ren,
  input  logic [4:0]  Rd_in,
  input  logic        WB_sel_in,
  output logic        mem_stall,
  output logic        resp_valid,
  output logic [31:0] rdata_out,
  output logic [4:0]  Rd_out,
  output logic        WB_sel_out,
  output logic        addr_err
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_access;
  logic             w_in_range;
  logic             w_arr_wen;
  logic [31:0]      w_arr_rdata;

  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_is_store;
  logic             r_resp_valid;
  logic             r_addr_err;
  logic [31:0]      r_rdata;
  logic [4:0]       r_rd;
  logic             r_wb_sel;

  // Range check uses the full address so aliases above DEPTH are rejected.
  assign w_in_range = (r_addr < 32'(DEPTH));
  assign w_arr_wen  = w_access && r_is_store && w_in_range && !reset;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_wen   (w_arr_wen),
    .i_addr  (r_addr[AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  // Next-state, latency counter and stall decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    mem_stall   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_wen || req_ren) begin
          w_accept    = 1'b1;
          mem_stall   = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (r_cnt == CNT_ZERO) begin
          w_access    = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request latch and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_is_store   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_addr_err   <= 1'b0;
      r_rdata      <= 32'd0;
      r_rd         <= 5'd0;
      r_wb_sel     <= 1'b0;
    end else begin
      r_resp_valid <= w_access;
      r_addr_err   <= w_access && !w_in_range;
      if (w_accept) begin
        // A simultaneous load is dropped; stores carry no destination.
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_is_store <= req_wen;
        r_rd       <= req_wen ? 5'd0 : Rd_in;
        r_wb_sel   <= WB_sel_in;
      end
      if (w_access && !r_is_store) begin
        r_rdata <= w_in_range ? w_arr_rdata : 32'd0;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign addr_err   = r_addr_err;
  assign rdata_out  = r_rdata;
  assign Rd_out     = r_rd;
  assign WB_sel_out = r_wb_sel;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words in the data array (power of two).
REQ-002 SHALL have parameter LATENCY, default 2: array access delay in cycles, legal range 1..7.
REQ-003 SHALL have one clock and a synchronous, active-high reset; both ports are listed below.
REQ-004 Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_addr  in  32  word address (byte address >> 2), from EX/MEM data_addr
- req_wdata  in  32  store data
- req_wen  in  1  store request
- req_ren  in  1  load request
- Rd_in  in  5  destination register
- WB_sel_in  in  1  writeback select
- mem_stall  out  1  pipeline hold request
- resp_valid  out  1  one-cycle completion pulse
- rdata_out  out  32  load data
- Rd_out  out  5  registered destination
- WB_sel_out  out  1  registered writeback select
- addr_err  out  1  out-of-range flag, qualified by resp_valid

Function
REQ-005 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-006 In IDLE with req_wen or req_ren high, SHALL latch the inputs and load the counter with LATENCY-1; next state is BUSY.
REQ-007 In IDLE with no request, SHALL stay in IDLE; outputs hold.
REQ-008 In BUSY, SHALL decrement the counter each cycle; when counter==0, SHALL perform the access and go to DONE.
REQ-009 In DONE, SHALL drive resp_valid=1 for exactly one cycle and then return to IDLE.
REQ-010 Latency: a request accepted in cycle N SHALL give resp_valid in cycle N+LATENCY+1.
REQ-011 mem_stall SHALL be combinational: 1 in IDLE while a request is present, 1 throughout BUSY, 0 in DONE.
REQ-012 Request inputs during BUSY or DONE SHALL be ignored; upstream holds them while stalled.
REQ-013 With req_wen and req_ren both high, SHALL treat the request as a store; the load is dropped.
REQ-014 Store: array[addr] SHALL be written with the latched wdata on the access cycle; rdata_out holds its previous value; Rd_out is forced to 0 at acceptance.
REQ-015 Load: rdata_out SHALL be loaded with array[addr] on the access cycle, be valid in DONE, and hold until the next load completes.
REQ-016 Rd_out and WB_sel_out SHALL update at acceptance and hold until the next acceptance.
REQ-017 Address >= DEPTH: SHALL make no array access; a load returns rdata_out=0; addr_err=1 alongside resp_valid, 0 otherwise.
REQ-018 Only the low log2(DEPTH) address bits SHALL index the array; in-range checking uses all 32 bits.
REQ-019 A store followed by a load to the same address SHALL return the stored data; there is no read-before-write hazard.

Reset
REQ-020 reset SHALL force state=IDLE, counter=0, and rdata_out, Rd_out, WB_sel_out, resp_valid and addr_err to 0.
REQ-021 Reset mid-operation (BUSY or DONE) SHALL abandon the transaction; a pending store SHALL NOT be written.
REQ-022 Array contents SHALL NOT be cleared by reset.
REQ-023 Reset SHALL take priority over any simultaneous request.

Structure
REQ-024 Package dmem_pkg SHALL hold the state enum (IDLE/BUSY/DONE), DEPTH_DEFAULT, LATENCY_DEFAULT and the counter width constant (3).
REQ-025 Sub-module dmem_array SHALL hold the storage: single port, synchronous write with enable, combinational read, parameterised by DEPTH.
REQ-026 The FSM, counter and output registers SHALL live in dmem_responder.

Verification
REQ-027 After reset, store addr=5 data=0xDEADBEEF in cycle N -> mem_stall=1 in N..N+2, resp_valid at N+3, addr_err=0, Rd_out=0.
REQ-028 Load addr=5 with Rd_in=7, WB_sel_in=1 after REQ-027 -> rdata_out=0xDEADBEEF, Rd_out=7, WB_sel_out=1 at resp_valid.
REQ-029 Load addr=300 (DEPTH=256) -> resp_valid with addr_err=1, rdata_out=0; array unchanged.
REQ-030 Simultaneous wen=ren=1, addr=9, data=0x12345678 -> treated as a store; a later load of addr 9 returns 0x12345678.
REQ-031 Store addr=3 data=0xAAAA5555, reset asserted in the first BUSY cycle -> FSM returns to IDLE, no resp_valid; a later load of addr 3 returns its prior value.
REQ-032 LATENCY=1 and LATENCY=7 builds, back-to-back loads -> resp_valid at N+2 and N+8 respectively, one pulse each.
